// File: rtl/tmds_roundtrip_checker.sv
// tmds_roundtrip_checker
//   Multi-channel TMDS loopback checker. Each channel encodes its input
//   character with the DVI TMDS algorithm and carries its own running
//   disparity. It decodes the result one stage later and compares it
//   against the registered input. Mismatches drive a saturating
//   per-channel counter. Disparity excursions set a sticky flag. A small
//   IDLE/RUN/FAILED FSM summarises the health of the whole block.
// Ports
//   clk        posedge clock for all logic
//   rst        synchronous active-high reset
//   din        data byte per channel, ch0 in [7:0]
//   ctrl_in    control bits {c1,c0} per channel, ch0 in [1:0]
//   data_en    1 = video-data period, 0 = control period
//   validin    input qualifier; compare/count only when set
//   clear_err  synchronous clear of err_count, disp_viol and FAILED
//   dout       decoded data bytes (0 in control periods)
//   ctrl_out   decoded control bits (0 in data periods)
//   den_out    data_en aligned with dout
//   validout   validin aligned with dout
//   mismatch   per-channel compare failure, aligned with validout
//   disp_viol  sticky per-channel |disparity| > DISP_LIMIT
//   err_count  per-channel saturating mismatch counters
//   state_fail FSM is in FAILED
module tmds_roundtrip_checker #(
  parameter int NUM_CH     = 3,
  parameter int CNT_W      = 16,
  parameter int DISP_LIMIT = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*8-1:0]     din,
  input  logic [NUM_CH*2-1:0]     ctrl_in,
  input  logic                    data_en,
  input  logic                    validin,
  input  logic                    clear_err,
  output logic [NUM_CH*8-1:0]     dout,
  output logic [NUM_CH*2-1:0]     ctrl_out,
  output logic                    den_out,
  output logic                    validout,
  output logic [NUM_CH-1:0]       mismatch,
  output logic [NUM_CH-1:0]       disp_viol,
  output logic [NUM_CH*CNT_W-1:0] err_count,
  output logic                    state_fail
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic signed [7:0] DISP_LIM = 8'(DISP_LIMIT);

  typedef struct packed {
    logic [9:0]        sym;
    logic signed [7:0] disp;
  } enc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAILED} state_t;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // DVI 1.0 TMDS encoder: transition minimisation followed by DC balancing
  // against the running disparity. Control characters reset the disparity.
  function automatic enc_t tmds_encode(input logic [7:0] d, input logic de,
                                       input logic [1:0] c,
                                       input logic signed [7:0] cnt);
    enc_t              r;
    logic [8:0]        q_m;
    logic              use_xnor;
    logic [3:0]        n1d;
    logic [3:0]        n1;
    logic signed [7:0] diff;
    n1d      = ones8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q_m[0]   = d[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
    q_m[8] = ~use_xnor;
    n1     = ones8(q_m[7:0]);
    diff   = $signed({3'b000, n1, 1'b0}) - 8'sd8;  // ones minus zeros
    r.sym  = '0;
    r.disp = '0;
    if (!de) begin
      case (c)
        2'b00:   r.sym = CTRL_00;
        2'b01:   r.sym = CTRL_01;
        2'b10:   r.sym = CTRL_10;
        default: r.sym = CTRL_11;
      endcase
    end else if ((cnt == 8'sd0) || (n1 == 4'd4)) begin
      r.sym  = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      r.disp = q_m[8] ? cnt + diff : cnt - diff;
    end else if (((cnt > 8'sd0) && (n1 > 4'd4)) || ((cnt < 8'sd0) && (n1 < 4'd4))) begin
      r.sym  = {1'b1, q_m[8], ~q_m[7:0]};
      r.disp = cnt + (q_m[8] ? 8'sd2 : 8'sd0) - diff;
    end else begin
      r.sym  = {1'b0, q_m[8], q_m[7:0]};
      r.disp = cnt - (q_m[8] ? 8'sd0 : 8'sd2) + diff;
    end
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] b;
    d    = s[9] ? ~s[7:0] : s[7:0];
    b[0] = d[0];
    for (int i = 1; i < 8; i++)
      b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return b;
  endfunction

  // Shared pipeline: expected values travel alongside the encoded chars.
  logic [NUM_CH*8-1:0] s1_din;
  logic [NUM_CH*2-1:0] s1_ctrl;
  logic                s1_den;
  logic                s1_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_din   <= '0;
      s1_ctrl  <= '0;
      s1_den   <= 1'b0;
      s1_valid <= 1'b0;
      den_out  <= 1'b0;
      validout <= 1'b0;
    end else begin
      s1_din   <= din;
      s1_ctrl  <= ctrl_in;
      s1_den   <= data_en;
      s1_valid <= validin;
      den_out  <= s1_den;
      validout <= s1_valid;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    enc_t              enc;
    logic [9:0]        s1_char;
    logic signed [7:0] disp_q;
    logic [7:0]        dec_byte;
    logic [1:0]        dec_ctrl;
    logic              ctrl_hit;
    logic              cmp_fail;
    logic              viol_hit;
    logic [7:0]        dout_q;
    logic [1:0]        ctrl_q;
    logic              mism_q;
    logic              viol_q;
    logic [CNT_W-1:0]  cnt_q;

    always_comb enc = tmds_encode(din[ch*8 +: 8], data_en, ctrl_in[ch*2 +: 2], disp_q);

    // S1: the disparity register always tracks the last encoded char, so it
    // keeps evolving while validin is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_char <= '0;
        disp_q  <= '0;
      end else begin
        s1_char <= enc.sym;
        disp_q  <= enc.disp;
      end
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
      dec_byte = tmds_decode(s1_char);
      dec_ctrl = 2'b00;
      ctrl_hit = 1'b1;
      cmp_fail = 1'b0;
      case (s1_char)
        CTRL_00: dec_ctrl = 2'b00;
        CTRL_01: dec_ctrl = 2'b01;
        CTRL_10: dec_ctrl = 2'b10;
        CTRL_11: dec_ctrl = 2'b11;
        default: ctrl_hit = 1'b0;
      endcase
      if (s1_den) cmp_fail = (dec_byte != s1_din[ch*8 +: 8]);
      else        cmp_fail = !ctrl_hit || (dec_ctrl != s1_ctrl[ch*2 +: 2]);
      // disp_q still holds the disparity produced by the S1 char here.
      viol_hit = s1_valid && s1_den && ((disp_q > DISP_LIM) || (disp_q < -DISP_LIM));
    end

    // S2 outputs plus error bookkeeping. A clear coinciding with a new event
    // keeps that event rather than dropping it.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        ctrl_q <= '0;
        mism_q <= 1'b0;
        viol_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        dout_q <= s1_den ? dec_byte : 8'h00;
        ctrl_q <= s1_den ? 2'b00 : dec_ctrl;
        mism_q <= s1_valid && cmp_fail;
        if (clear_err)     viol_q <= viol_hit;
        else if (viol_hit) viol_q <= 1'b1;
        if (clear_err)                cnt_q <= CNT_W'(mism_q);
        else if (mism_q && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign dout[ch*8 +: 8]          = dout_q;
    assign ctrl_out[ch*2 +: 2]      = ctrl_q;
    assign mismatch[ch]             = mism_q;
    assign disp_viol[ch]            = viol_q;
    assign err_count[ch*CNT_W +: CNT_W] = cnt_q;
  end

  // Block-level health FSM.
  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (validout) state_d = ST_RUN;
      ST_RUN:    if ((|mismatch) || (|disp_viol)) state_d = ST_FAILED;
      ST_FAILED: if (clear_err) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb state_fail = (state_q == ST_FAILED);

endmodule

// File: tb/tb_tmds_roundtrip_checker.sv
// Directed bench for tmds_roundtrip_checker. Three instances share stimulus:
// the default build, a CNT_W=4 build for saturation, and a DISP_LIMIT=0 build
// for the disparity-violation flag.
module tb_tmds_roundtrip_checker;

  logic        clk;
  logic        rst;
  logic [23:0] din;
  logic [5:0]  ctrl_in;
  logic        data_en;
  logic        validin;
  logic        clear_err;

  logic [23:0] dout,       dout_s,       dout_l;
  logic [5:0]  ctrl_out,   ctrl_out_s,   ctrl_out_l;
  logic        den_out,    den_out_s,    den_out_l;
  logic        validout,   validout_s,   validout_l;
  logic [2:0]  mismatch,   mismatch_s,   mismatch_l;
  logic [2:0]  disp_viol,  disp_viol_s,  disp_viol_l;
  logic [47:0] err_count;
  logic [11:0] err_count_s;
  logic [47:0] err_count_l;
  logic        state_fail, state_fail_s, state_fail_l;

  int checks   = 0;
  int failures = 0;

  tmds_roundtrip_checker #(.NUM_CH(3), .CNT_W(16), .DISP_LIMIT(10)) dut (
    .clk(clk), .rst(rst), .din(din), .ctrl_in(ctrl_in), .data_en(data_en),
    .validin(validin), .clear_err(clear_err), .dout(dout), .ctrl_out(ctrl_out),
    .den_out(den_out), .validout(validout), .mismatch(mismatch),
    .disp_viol(disp_viol), .err_count(err_count), .state_fail(state_fail));

  tmds_roundtrip_checker #(.NUM_CH(3), .CNT_W(4), .DISP_LIMIT(10)) dut_s (
    .clk(clk), .rst(rst), .din(din), .ctrl_in(ctrl_in), .data_en(data_en),
    .validin(validin), .clear_err(clear_err), .dout(dout_s), .ctrl_out(ctrl_out_s),
    .den_out(den_out_s), .validout(validout_s), .mismatch(mismatch_s),
    .disp_viol(disp_viol_s), .err_count(err_count_s), .state_fail(state_fail_s));

  tmds_roundtrip_checker #(.NUM_CH(3), .CNT_W(16), .DISP_LIMIT(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .ctrl_in(ctrl_in), .data_en(data_en),
    .validin(validin), .clear_err(clear_err), .dout(dout_l), .ctrl_out(ctrl_out_l),
    .den_out(den_out_l), .validout(validout_l), .mismatch(mismatch_l),
    .disp_viol(disp_viol_l), .err_count(err_count_l), .state_fail(state_fail_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; din = '0; ctrl_in = '0; data_en = 1'b0; validin = 1'b0; clear_err = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_dout", dout, 24'h0);
    check("rst_validout", validout, 1'b0);
    check("rst_mismatch", mismatch, 3'b000);
    check("rst_err_count", err_count, 48'h0);
    check("rst_disp_viol", disp_viol, 3'b000);
    check("rst_state_fail", state_fail, 1'b0);
    rst = 1'b0;

    // 1: data ramp, dout follows din two edges later
    for (int i = 0; i < 257; i++) begin
      logic [7:0] b;
      logic [7:0] bp;
      b = 8'(i);
      bp = 8'(i - 1);
      din = {3{b}}; data_en = 1'b1; validin = 1'b1;
      tick();
      if (i >= 1) begin
        check("t1_dout", dout, {3{bp}});
        check("t1_mismatch", mismatch, 3'b000);
        check("t1_validout", validout, 1'b1);
      end
    end
    check("t1_err_count", err_count, 48'h0);
    check("t1_den_out", den_out, 1'b1);
    check("t1_state_run", 64'(dut.state_q), 64'd1);
    check("t1_state_fail", state_fail, 1'b0);

    // 2: control period, disparity zeroed by every control char
    for (int j = 0; j < 6; j++) begin
      logic [1:0] c;
      logic [1:0] cp;
      c = 2'(j);
      cp = 2'(j - 1);
      ctrl_in = {3{c}}; data_en = 1'b0;
      tick();
      check("t2_disp_ch0", $unsigned(dut.g_ch[0].disp_q), 8'h00);
      check("t2_disp_ch2", $unsigned(dut.g_ch[2].disp_q), 8'h00);
      if (j >= 1) begin
        check("t2_ctrl_out", ctrl_out, {3{cp}});
        check("t2_dout", dout, 24'h0);
        check("t2_mismatch", mismatch, 3'b000);
        check("t2_den_out", den_out, 1'b0);
      end
    end

    // 3: corrupt ch1 S1 char (0x55 encodes to balanced 0x133; bit0 flip decodes to 0x56)
    ctrl_in = '0; data_en = 1'b1; din = {3{8'h55}}; validin = 1'b0;
    repeat (3) tick();
    check("t3_pre_mismatch", mismatch, 3'b000);
    validin = 1'b1;
    tick();
    force dut.g_ch[1].s1_char = 10'h132;
    tick();
    check("t3_mis1", mismatch, 3'b010);
    check("t3_dout_corrupt", dout, 24'h555655);
    tick();
    check("t3_mis2", mismatch, 3'b010);
    validin = 1'b0;
    tick();
    check("t3_mis3", mismatch, 3'b010);
    release dut.g_ch[1].s1_char;
    tick();
    check("t3_mis_end", mismatch, 3'b000);
    check("t3_err_count", err_count, {16'd0, 16'd3, 16'd0});
    check("t3_state_fail", state_fail, 1'b1);
    check("t3_other_dut_clean", err_count_s, 12'h000);

    // 4: CNT_W=4 build saturates at 15, then clear_err
    force dut_s.g_ch[1].s1_char = 10'h132;
    validin = 1'b1;
    repeat (20) tick();
    validin = 1'b0;
    repeat (3) tick();
    release dut_s.g_ch[1].s1_char;
    tick();
    check("t4_err_sat", err_count_s, 12'h0F0);
    check("t4_state_fail_s", state_fail_s, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_err_cleared_s", err_count_s, 12'h000);
    check("t4_state_idle_s", state_fail_s, 1'b0);
    check("t4_err_cleared", err_count, 48'h0);
    check("t4_state_idle", state_fail, 1'b0);
    check("t4_viol_cleared_l", disp_viol_l, 3'b000);
    tick();
    check("t4_state_stays", state_fail, 1'b0);

    // clear_err coinciding with a mismatch loads 1
    force dut.g_ch[1].s1_char = 10'h132;
    validin = 1'b1;
    tick();
    validin = 1'b0;
    tick();
    check("t4_mis_at_clear", mismatch, 3'b010);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    release dut.g_ch[1].s1_char;
    check("t4_clear_loads_1", err_count, {16'd0, 16'd1, 16'd0});
    tick();

    // 5: alternating 0x00/0xFF keeps |disparity| <= 8; DISP_LIMIT=0 trips at once
    validin = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      din = (k % 2 == 0) ? 24'h000000 : 24'hFFFFFF;
      tick();
      check("t5_mismatch", mismatch, 3'b000);
      if (k == 0) check("t5_lim0_before", disp_viol_l, 3'b000);
      if (k == 1) check("t5_lim0_first", disp_viol_l, 3'b111);
    end
    check("t5_disp_viol", disp_viol, 3'b000);
    check("t5_err_count", err_count, {16'd0, 16'd1, 16'd0});
    check("t5_state_fail", state_fail, 1'b0);

    // 6: reset mid-stream with validin high
    data_en = 1'b0;
    tick();
    data_en = 1'b1; din = 24'hFFFFFF;
    tick();
    check("t6_pre_disp", $unsigned(dut.g_ch[0].disp_q), 8'hF8);
    rst = 1'b1;
    tick();
    check("t6_validout", validout, 1'b0);
    check("t6_dout", dout, 24'h0);
    check("t6_den_out", den_out, 1'b0);
    check("t6_ctrl_out", ctrl_out, 6'h0);
    check("t6_err_count", err_count, 48'h0);
    check("t6_state_fail", state_fail, 1'b0);
    check("t6_viol_l", disp_viol_l, 3'b000);
    check("t6_disp_zero", $unsigned(dut.g_ch[0].disp_q), 8'h00);
    rst = 1'b0;
    tick();
    check("t6_first_char", dut.g_ch[0].s1_char, 10'h200);
    check("t6_first_disp", $unsigned(dut.g_ch[0].disp_q), 8'hF8);
    tick();
    check("t6_dout_after", dout, 24'hFFFFFF);
    check("t6_validout_after", validout, 1'b1);
    check("t6_mismatch_after", mismatch, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
